// File: rtl/dirty_bank_ctrl.sv
// Dirty-state tracker for a bank of NREG registers, plus a sequencer that walks the bank
// and requests a save of every DIRTY register. A write during a save keeps the register dirty.
module dirty_bank_ctrl #(
  parameter int NREG  = 8,
  parameter int IDX_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr_off,
  input  logic [NREG-1:0]   ld_reg,
  input  logic [NREG-1:0]   rst_reg,
  input  logic              backup_en,
  output logic              backup_req,
  output logic [IDX_W-1:0]  backup_idx,
  input  logic              backup_ack,
  output logic              backup_busy,
  output logic              backup_done,
  output logic [2*NREG-1:0] dirty_val,
  output logic              dirty_any
);

  localparam logic [1:0] ST_CLEAN    = 2'b00;
  localparam logic [1:0] ST_DIRTY    = 2'b01;
  localparam logic [1:0] ST_READ     = 2'b10;
  localparam logic [1:0] ST_DIRTY_WR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } seq_t;

  seq_t              seq_q, seq_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [2*NREG-1:0] state_q, state_d;
  logic [NREG-1:0]   wr;
  logic              ptr_dirty, ptr_last, grant, ack_hit;

  assign wr        = ld_reg | rst_reg;
  assign ptr_dirty = (state_q[{ptr_q, 1'b0} +: 2] == ST_DIRTY);
  assign ptr_last  = (ptr_q == IDX_W'(NREG - 1));
  assign grant     = (seq_q == S_SCAN) && ptr_dirty;
  // An ack only counts while a request is actually outstanding.
  assign ack_hit   = (seq_q == S_REQ) && backup_ack;

  always_comb begin
    seq_d = seq_q;
    ptr_d = ptr_q;
    if (pwr_off) begin
      seq_d = S_IDLE;
      ptr_d = '0;
    end else begin
      case (seq_q)
        S_IDLE: if (backup_en) begin
          seq_d = S_SCAN;
          ptr_d = '0;
        end
        S_SCAN: begin
          if (ptr_dirty) begin
            seq_d = S_REQ;
          end else if (ptr_last) begin
            seq_d = S_DONE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        S_REQ: if (backup_ack) begin
          if (ptr_last) begin
            seq_d = S_DONE;
          end else begin
            seq_d = S_SCAN;
            ptr_d = ptr_q + 1'b1;
          end
        end
        default: seq_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NREG; i++) begin
      case (state_q[2*i +: 2])
        ST_CLEAN: begin
          if (wr[i]) state_d[2*i +: 2] = ST_DIRTY;
        end
        ST_DIRTY: begin
          if (grant && (ptr_q == IDX_W'(i))) state_d[2*i +: 2] = ST_READ;
        end
        ST_READ: begin
          if (ack_hit && (ptr_q == IDX_W'(i))) begin
            state_d[2*i +: 2] = wr[i] ? ST_DIRTY : ST_CLEAN;
          end else if (wr[i]) begin
            state_d[2*i +: 2] = ST_DIRTY_WR;
          end
        end
        default: begin
          // Newer data arrived after the save started, so the ack cannot clean it.
          if (ack_hit && (ptr_q == IDX_W'(i))) state_d[2*i +: 2] = ST_DIRTY;
        end
      endcase
    end
    if (pwr_off) state_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q   <= S_IDLE;
      ptr_q   <= '0;
      state_q <= '0;
    end else begin
      seq_q   <= seq_d;
      ptr_q   <= ptr_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    dirty_any = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      dirty_any = dirty_any | (|state_q[2*i +: 2]);
    end
  end

  assign dirty_val   = state_q;
  assign backup_idx  = ptr_q;
  assign backup_req  = (seq_q == S_REQ);
  assign backup_busy = (seq_q != S_IDLE);
  assign backup_done = (seq_q == S_DONE);

endmodule

// File: tb/tb_dirty_bank_ctrl.sv
// Directed self-checking bench for dirty_bank_ctrl (NREG=8): hand-computed expectations
// checked with immediate assertions after each step.
module tb_dirty_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwr_off;
  logic [7:0]  ld_reg;
  logic [7:0]  rst_reg;
  logic        backup_en;
  logic        backup_req;
  logic [2:0]  backup_idx;
  logic        backup_ack;
  logic        backup_busy;
  logic        backup_done;
  logic [15:0] dirty_val;
  logic        dirty_any;

  int checks = 0;
  int errors = 0;

  dirty_bank_ctrl #(.NREG(8), .IDX_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwr_off     (pwr_off),
    .ld_reg      (ld_reg),
    .rst_reg     (rst_reg),
    .backup_en   (backup_en),
    .backup_req  (backup_req),
    .backup_idx  (backup_idx),
    .backup_ack  (backup_ack),
    .backup_busy (backup_busy),
    .backup_done (backup_done),
    .dirty_val   (dirty_val),
    .dirty_any   (dirty_any)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!backup_req && n < 30) begin
      step();
      n++;
    end
    chk(tag, {31'd0, backup_req}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, output int ndone);
    int n = 0;
    ndone = 0;
    while (backup_busy && n < 40) begin
      if (backup_done) ndone++;
      step();
      n++;
    end
    chk(tag, {31'd0, backup_busy}, 32'd0);
  endtask

  initial begin
    int cyc, nreq, age, ndone;
    logic [2:0] idxs [4];
    logic saw_req;

    rst_n = 1'b0; pwr_off = 1'b0; ld_reg = '0; rst_reg = '0;
    backup_en = 1'b0; backup_ack = 1'b0;
    idxs[0] = '0; idxs[1] = '0; idxs[2] = '0; idxs[3] = '0;
    #2;
    chk("rst_dirty_val", dirty_val, 0);
    chk("rst_busy", backup_busy, 0);
    chk("rst_req_done_any", {backup_req, backup_done, dirty_any}, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Two dirty registers (2, 5); ack one cycle after each request appears.
    ld_reg = 8'h24; step(); ld_reg = '0;
    chk("ld24_dirty_val", dirty_val, 16'h0410);
    chk("ld24_any", dirty_any, 1);
    backup_en = 1'b1; step(); backup_en = 1'b0;
    cyc = 0; nreq = 0; age = 0; ndone = 0;
    while (backup_busy && cyc < 40) begin
      cyc++;
      backup_ack = 1'b0;
      if (backup_done) ndone++;
      if (backup_req) begin
        if (age == 0 && nreq < 4) begin
          idxs[nreq] = backup_idx;
          nreq++;
        end
        if (age == 1) backup_ack = 1'b1;
        age++;
      end else begin
        age = 0;
      end
      step();
    end
    backup_ack = 1'b0;
    chk("pass_len", cyc, 13);
    chk("pass_nreq", nreq, 2);
    chk("pass_idx0", idxs[0], 2);
    chk("pass_idx1", idxs[1], 5);
    chk("pass_ndone", ndone, 1);
    chk("pass_clean", dirty_val, 0);
    chk("pass_any", dirty_any, 0);

    // Write to reg 3 while its save is outstanding.
    rst_reg = 8'h08; step(); rst_reg = '0;
    backup_en = 1'b1; step(); backup_en = 1'b0;
    wait_req("r3_wait_req");
    chk("r3_idx", backup_idx, 3);
    chk("r3_read", dirty_val[7:6], 2'b10);
    ld_reg = 8'h08; step(); ld_reg = '0;
    chk("r3_dirty_wr", dirty_val[7:6], 2'b11);
    step();
    chk("r3_req_held", {backup_req, backup_idx}, {1'b1, 3'd3});
    backup_ack = 1'b1; step(); backup_ack = 1'b0;
    chk("r3_after_ack", dirty_val[7:6], 2'b01);
    chk("r3_any", dirty_any, 1);
    chk("r3_ptr", backup_idx, 4);
    wait_idle("r3_idle", ndone);
    chk("r3_still_dirty", dirty_val[7:6], 2'b01);

    // Power-off beats simultaneous writes.
    pwr_off = 1'b1; ld_reg = 8'hFF; step(); pwr_off = 1'b0; ld_reg = '0;
    chk("pwroff_over_ld", dirty_val, 0);

    // Write and ack in the same cycle on reg 0.
    ld_reg = 8'h01; step(); ld_reg = '0;
    backup_en = 1'b1; step(); backup_en = 1'b0;
    wait_req("r0_wait_req");
    chk("r0_idx", backup_idx, 0);
    ld_reg = 8'h01; backup_ack = 1'b1; step(); ld_reg = '0; backup_ack = 1'b0;
    chk("r0_dirty", dirty_val[1:0], 2'b01);
    chk("r0_ptr", backup_idx, 1);
    chk("r0_scan", {backup_busy, backup_req}, 2'b10);
    wait_idle("r0_idle", ndone);
    pwr_off = 1'b1; step(); pwr_off = 1'b0;

    // Ack in IDLE has no effect; write behind ptr waits for the next pass.
    ld_reg = 8'h40; step(); ld_reg = '0;
    backup_ack = 1'b1; step(); backup_ack = 1'b0;
    chk("idle_ack_ignored", dirty_val, 16'h1000);
    backup_en = 1'b1; step(); backup_en = 1'b0;
    wait_req("r6_wait_req");
    chk("r6_idx", backup_idx, 6);
    ld_reg = 8'h02; step(); ld_reg = '0;
    backup_ack = 1'b1; step(); backup_ack = 1'b0;
    wait_idle("r6_idle", ndone);
    chk("r6_ndone", ndone, 1);
    chk("r6_behind_ptr", dirty_val, 16'h0004);
    backup_en = 1'b1; step(); backup_en = 1'b0;
    wait_req("r1_wait_req");
    chk("r1_idx", backup_idx, 1);
    backup_ack = 1'b1; step(); backup_ack = 1'b0;
    wait_idle("r1_idle", ndone);
    chk("r1_clean", dirty_val, 0);

    // Power-off mid-request.
    ld_reg = 8'hFF; step(); ld_reg = '0;
    backup_en = 1'b1; step(); backup_en = 1'b0;
    wait_req("pw_wait_req");
    pwr_off = 1'b1; step(); pwr_off = 1'b0;
    chk("pw_dirty_val", dirty_val, 0);
    chk("pw_busy_req_done", {backup_busy, backup_req, backup_done}, 0);
    step();
    chk("pw_no_done", {backup_busy, backup_done}, 0);

    // Async reset mid-request clears without a clock edge.
    ld_reg = 8'hFF; step(); ld_reg = '0;
    backup_en = 1'b1; step(); backup_en = 1'b0;
    wait_req("rs_wait_req");
    #2 rst_n = 1'b0;
    #1;
    chk("rs_dirty_val", dirty_val, 0);
    chk("rs_outputs", {backup_busy, backup_req, backup_done, dirty_any}, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rs_no_done", {backup_busy, backup_done}, 0);

    // All clean: pass of 8 scan cycles, done in the 9th cycle from the enable edge.
    backup_en = 1'b1; step(); backup_en = 1'b0;
    saw_req = backup_req;
    for (int k = 0; k < 7; k++) begin
      step();
      saw_req = saw_req | backup_req;
    end
    chk("clean_pre_done", {backup_busy, backup_done}, 2'b10);
    step();
    chk("clean_done", backup_done, 1);
    step();
    chk("clean_after", {backup_busy, backup_done}, 0);
    chk("clean_no_req", saw_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
